// File: rtl/ddram_burst_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : ddram_burst_exerciser
//  Description : Avalon-MM burst traffic generator / checker for DDRAM bring-up.
//                Issues read, write or write-then-verify bursts with a
//                configurable base address, length and inter-burst gap, and
//                supports a clean stop at a burst boundary or an abrupt abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddram_burst_exerciser #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 64,
    parameter int BURST_MAX = 128,
    parameter int WAIT_W    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            i_cfg_burst,
    input  logic [ADDR_W-1:0]     i_cfg_addr,
    input  logic [WAIT_W-1:0]     i_cfg_gap,
    input  logic [1:0]            i_cfg_mode,
    input  logic                  i_cfg_hold,
    input  logic                  i_safe_stop,
    input  logic                  i_abort,
    input  logic                  i_ddr_busy,
    output logic [7:0]            o_ddr_burstcnt,
    output logic [ADDR_W-1:0]     o_ddr_addr,
    input  logic [DATA_W-1:0]     i_ddr_dout,
    input  logic                  i_ddr_dout_rdy,
    output logic                  o_ddr_rd,
    output logic [DATA_W-1:0]     o_ddr_din,
    output logic [DATA_W/8-1:0]   o_ddr_be,
    output logic                  o_ddr_we,
    output logic                  o_running,
    output logic                  o_stopped,
    output logic                  o_err,
    output logic [15:0]           o_err_cnt,
    output logic [31:0]           o_burst_num
);

    localparam logic [7:0] c_BURST_MAX = 8'(BURST_MAX);
    localparam logic [1:0] c_MODE_RD   = 2'd0;
    localparam logic [1:0] c_MODE_WV   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_WR      = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_STOPPED = 3'd5
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_gap_cnt;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic [1:0]          r_mode;
    logic                r_hold;
    logic [ADDR_W-1:0]   r_base;
    logic                r_safe;
    logic                r_rd;
    logic                r_we;
    logic [7:0]          r_burstcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic                r_err;
    logic [15:0]         r_err_cnt;
    logic [31:0]         r_burst_num;

    logic [7:0]          w_len;
    logic [1:0]          w_mode;
    logic [7:0]          w_beat_nxt;
    logic                w_last;
    logic                w_stop_req;
    logic                w_mismatch;

    // Data word for beat b of burst n: burst number above, beat index in the low byte.
    function automatic logic [DATA_W-1:0] f_pattern(input logic [31:0] n, input logic [7:0] b);
        return DATA_W'({n, b});
    endfunction

    // Clamp the requested burst length into 1..BURST_MAX and fold the reserved mode onto read.
    always_comb begin
        w_len = i_cfg_burst;
        if (i_cfg_burst == 8'd0) begin
            w_len = 8'd1;
        end else if (i_cfg_burst > c_BURST_MAX) begin
            w_len = c_BURST_MAX;
        end
    end

    assign w_mode     = (i_cfg_mode == 2'd3) ? c_MODE_RD : i_cfg_mode;
    assign w_beat_nxt = r_beat + 8'd1;
    assign w_last     = (r_beat == (r_len - 8'd1));
    // A stop request arriving on the completing cycle itself is honoured too.
    assign w_stop_req = r_safe | i_safe_stop;
    assign w_mismatch = (i_ddr_dout != f_pattern(r_burst_num, r_beat));

    // Burst sequencer: gap timing, command/beat issue, read checking and stop handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_len       <= 8'd1;
            r_beat      <= '0;
            r_mode      <= c_MODE_RD;
            r_hold      <= 1'b0;
            r_base      <= '0;
            r_safe      <= 1'b0;
            r_rd        <= 1'b0;
            r_we        <= 1'b0;
            r_burstcnt  <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_burst_num <= '0;
        end else begin
            if (i_safe_stop) begin
                r_safe <= 1'b1;
            end
            if (i_abort && (r_state != S_STOPPED)) begin
                // Deliberately drops rd/we mid-burst to stress the controller.
                r_state <= S_STOPPED;
                r_rd    <= 1'b0;
                r_we    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                    S_GAP: begin
                        if (r_gap_cnt >= i_cfg_gap) begin
                            r_gap_cnt  <= '0;
                            r_len      <= w_len;
                            r_mode     <= w_mode;
                            r_hold     <= i_cfg_hold;
                            r_base     <= i_cfg_addr;
                            r_beat     <= '0;
                            r_burstcnt <= w_len;
                            r_addr     <= i_cfg_addr;
                            if (w_mode == c_MODE_RD) begin
                                r_rd    <= 1'b1;
                                r_state <= S_RD_REQ;
                            end else begin
                                r_we    <= 1'b1;
                                r_din   <= f_pattern(r_burst_num, 8'd0);
                                r_state <= S_WR;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + WAIT_W'(1);
                        end
                    end
                    S_WR: begin
                        if (!i_ddr_busy) begin
                            if (!r_hold) begin
                                r_burstcnt <= 8'd1;
                                r_addr     <= '0;
                            end
                            if (w_last) begin
                                r_we <= 1'b0;
                                if (r_mode == c_MODE_WV) begin
                                    // Verify read of the same region follows directly.
                                    r_rd       <= 1'b1;
                                    r_burstcnt <= r_len;
                                    r_addr     <= r_base;
                                    r_state    <= S_RD_REQ;
                                end else begin
                                    r_burst_num <= r_burst_num + 32'd1;
                                    r_state     <= w_stop_req ? S_STOPPED : S_GAP;
                                end
                            end else begin
                                r_beat <= w_beat_nxt;
                                r_din  <= f_pattern(r_burst_num, w_beat_nxt);
                            end
                        end
                    end
                    S_RD_REQ: begin
                        if (!i_ddr_busy) begin
                            r_rd    <= 1'b0;
                            r_beat  <= '0;
                            r_state <= S_RD_DATA;
                            if (!r_hold) begin
                                r_burstcnt <= 8'd1;
                                r_addr     <= '0;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (i_ddr_dout_rdy) begin
                            if ((r_mode == c_MODE_WV) && w_mismatch) begin
                                r_err <= 1'b1;
                                if (r_err_cnt != 16'hFFFF) begin
                                    r_err_cnt <= r_err_cnt + 16'd1;
                                end
                            end
                            if (w_last) begin
                                r_burst_num <= r_burst_num + 32'd1;
                                r_state     <= w_stop_req ? S_STOPPED : S_GAP;
                            end else begin
                                r_beat <= w_beat_nxt;
                            end
                        end
                    end
                    S_STOPPED: begin
                        r_rd <= 1'b0;
                        r_we <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ddr_rd       = r_rd;
    assign o_ddr_we       = r_we;
    assign o_ddr_burstcnt = r_burstcnt;
    assign o_ddr_addr     = r_addr;
    assign o_ddr_din      = r_din;
    assign o_ddr_be       = '1;
    assign o_running      = (r_state != S_IDLE) && (r_state != S_STOPPED);
    assign o_stopped      = (r_state == S_STOPPED);
    assign o_err          = r_err;
    assign o_err_cnt      = r_err_cnt;
    assign o_burst_num    = r_burst_num;

endmodule
`default_nettype wire

// File: tb/tb_ddram_burst_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddram_burst_exerciser
//  Description : Directed bench for ddram_burst_exerciser with a small DDRAM
//                responder (busy shaping, echo memory, 2-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddram_burst_exerciser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_cfg_burst;
    logic [28:0] i_cfg_addr;
    logic [9:0]  i_cfg_gap;
    logic [1:0]  i_cfg_mode;
    logic        i_cfg_hold;
    logic        i_safe_stop;
    logic        i_abort;
    logic        i_ddr_busy;
    logic [7:0]  o_ddr_burstcnt;
    logic [28:0] o_ddr_addr;
    logic [63:0] i_ddr_dout;
    logic        i_ddr_dout_rdy;
    logic        o_ddr_rd;
    logic [63:0] o_ddr_din;
    logic [7:0]  o_ddr_be;
    logic        o_ddr_we;
    logic        o_running;
    logic        o_stopped;
    logic        o_err;
    logic [15:0] o_err_cnt;
    logic [31:0] o_burst_num;

    int total = 0;
    int bad   = 0;

    // Responder state
    logic [63:0] mem [0:1023];
    int cyc = 0;
    int busy_mode = 0;          // 0: never busy, 1: toggling, 2: always busy
    int wr_idx, wr_base, wr_cnt, wr_beats;
    int rd_pend, rd_start, rd_base, rd_cnt, rd_idx, rd_cur, rd_served, rd_cmds, rd_beats;
    int corrupt_burst = -1;
    int corrupt_beat  = -1;

    always #5 clk = ~clk;

    ddram_burst_exerciser #(
        .ADDR_W(29), .DATA_W(64), .BURST_MAX(128), .WAIT_W(10)
    ) dut (
        .clk(clk), .reset(reset),
        .i_cfg_burst(i_cfg_burst), .i_cfg_addr(i_cfg_addr), .i_cfg_gap(i_cfg_gap),
        .i_cfg_mode(i_cfg_mode), .i_cfg_hold(i_cfg_hold),
        .i_safe_stop(i_safe_stop), .i_abort(i_abort), .i_ddr_busy(i_ddr_busy),
        .o_ddr_burstcnt(o_ddr_burstcnt), .o_ddr_addr(o_ddr_addr),
        .i_ddr_dout(i_ddr_dout), .i_ddr_dout_rdy(i_ddr_dout_rdy),
        .o_ddr_rd(o_ddr_rd), .o_ddr_din(o_ddr_din), .o_ddr_be(o_ddr_be), .o_ddr_we(o_ddr_we),
        .o_running(o_running), .o_stopped(o_stopped), .o_err(o_err),
        .o_err_cnt(o_err_cnt), .o_burst_num(o_burst_num)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        wr_idx = 0; wr_base = 0; wr_cnt = 1; wr_beats = 0;
        rd_pend = 0; rd_start = 0; rd_base = 0; rd_cnt = 1; rd_idx = 0;
        rd_cur = 0; rd_served = 0; rd_cmds = 0; rd_beats = 0;
    endtask

    function automatic logic sel_flag(input int which);
        case (which)
            0:       return o_ddr_rd;
            1:       return o_ddr_we;
            2:       return o_stopped;
            default: return i_ddr_dout_rdy;
        endcase
    endfunction

    // Advance at least one cycle, then wait (bounded) for the selected flag.
    task automatic wait_flag(input int which, input int budget, input string tag);
        int   n;
        logic f;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
            f = sel_flag(which);
        end while (!f && n < budget);
        check(tag, {63'd0, f}, 64'd1);
    endtask

    task automatic wait_bn(input logic [31:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (o_burst_num < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, {63'd0, (o_burst_num >= target)}, 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk); #1;
        reset = 1'b1; i_safe_stop = 1'b0; i_abort = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        clear_model();
        reset = 1'b0;
    endtask

    // DDRAM responder: observes the cycle at negedge, drives the next cycle after posedge.
    initial begin : responder
        logic [63:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_ddr_we && !i_ddr_busy) begin
                if (wr_idx == 0) begin
                    wr_base = int'(o_ddr_addr[9:0]);
                    wr_cnt  = int'(o_ddr_burstcnt);
                end
                mem[(wr_base + wr_idx) % 1024] = o_ddr_din;
                wr_idx++; wr_beats++;
                if (wr_idx >= wr_cnt) wr_idx = 0;
            end
            if (o_ddr_rd && !i_ddr_busy) begin
                rd_pend = 1; rd_start = cyc + 2;
                rd_base = int'(o_ddr_addr[9:0]); rd_cnt = int'(o_ddr_burstcnt);
                rd_idx = 0; rd_cur = rd_served; rd_served++; rd_cmds++;
            end
            @(posedge clk); #1;
            i_ddr_busy = (busy_mode == 2) || (busy_mode == 1 && cyc[0] == 1'b0);
            if (rd_pend != 0 && cyc + 1 >= rd_start) begin
                d = mem[(rd_base + rd_idx) % 1024];
                if (rd_cur == corrupt_burst && rd_idx == corrupt_beat) d = d ^ 64'h0010_0000;
                i_ddr_dout = d; i_ddr_dout_rdy = 1'b1;
                rd_idx++; rd_beats++;
                if (rd_idx >= rd_cnt) rd_pend = 0;
            end else begin
                i_ddr_dout = '0; i_ddr_dout_rdy = 1'b0;
            end
        end
    end

    initial begin : main
        int beats, last, nxt, rds;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_model();
        reset = 1'b1; i_safe_stop = 1'b0; i_abort = 1'b0;
        i_ddr_busy = 1'b0; i_ddr_dout = '0; i_ddr_dout_rdy = 1'b0;
        i_cfg_burst = 8'd4; i_cfg_addr = 29'h100; i_cfg_gap = 10'd0;
        i_cfg_mode = 2'd0; i_cfg_hold = 1'b1;

        // Reset state
        repeat (2) begin @(negedge clk); #1; end
        check("rst_rd",        {63'd0, o_ddr_rd},  0);
        check("rst_we",        {63'd0, o_ddr_we},  0);
        check("rst_burstcnt",  {56'd0, o_ddr_burstcnt}, 0);
        check("rst_addr",      {35'd0, o_ddr_addr}, 0);
        check("rst_din",       o_ddr_din, 0);
        check("rst_running",   {63'd0, o_running}, 0);
        check("rst_stopped",   {63'd0, o_stopped}, 0);
        check("rst_err",       {63'd0, o_err},     0);
        check("rst_err_cnt",   {48'd0, o_err_cnt}, 0);
        check("rst_burst_num", {32'd0, o_burst_num}, 0);
        check("rst_be",        {56'd0, o_ddr_be},  64'hFF);
        clear_model();
        reset = 1'b0;

        // Test 1: mode0, L=4, gap=0, read latency 2
        wait_flag(0, 20, "t1_rd_seen");
        check("t1_burstcnt", {56'd0, o_ddr_burstcnt}, 4);
        check("t1_addr",     {35'd0, o_ddr_addr}, 64'h100);
        check("t1_running",  {63'd0, o_running}, 1);
        beats = 0; last = 0; nxt = 0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk); #1;
            if (t == 1) check("t1_rd_one_cycle", {63'd0, o_ddr_rd}, 0);
            if (i_ddr_dout_rdy) begin beats++; last = t; end
            if (o_ddr_rd && nxt == 0) nxt = t;
            if (t == 7) check("t1_burst_num", {32'd0, o_burst_num}, 1);
        end
        check("t1_beats",     beats, 4);
        check("t1_last_beat", last, 5);
        check("t1_next_rd",   nxt, 7);

        // Test 2: mode2, L=128, busy toggling, echo memory
        i_cfg_mode = 2'd2; i_cfg_burst = 8'd128; i_cfg_addr = 29'h200; i_cfg_gap = 10'd3;
        busy_mode = 1;
        apply_reset();
        wait_bn(1, 3000, "t2_pair1_done");
        check("t2_wr_beats1", wr_beats, 128);
        check("t2_rd_beats1", rd_beats, 128);
        check("t2_bn1",       {32'd0, o_burst_num}, 1);
        wait_bn(2, 3000, "t2_pair2_done");
        check("t2_wr_beats2", wr_beats, 256);
        check("t2_rd_beats2", rd_beats, 256);
        check("t2_err",       {63'd0, o_err}, 0);

        // Test 3: corrupted beat 5 of burst 3
        busy_mode = 0; i_cfg_burst = 8'd8; i_cfg_gap = 10'd1; i_cfg_hold = 1'b0;
        i_cfg_addr = 29'h40;
        corrupt_burst = 3; corrupt_beat = 5;
        apply_reset();
        wait_bn(3, 500, "t3_bn3");
        check("t3_err_before",  {63'd0, o_err}, 0);
        wait_bn(4, 500, "t3_bn4");
        check("t3_err_after",   {63'd0, o_err}, 1);
        check("t3_errcnt_after", {48'd0, o_err_cnt}, 1);
        wait_bn(6, 500, "t3_bn6");
        check("t3_errcnt_keep", {48'd0, o_err_cnt}, 1);
        corrupt_burst = -1; corrupt_beat = -1;
        apply_reset();
        @(negedge clk); #1;
        check("t3_err_rst",    {63'd0, o_err}, 0);
        check("t3_errcnt_rst", {48'd0, o_err_cnt}, 0);

        // Test 4: clamping and cfg_hold=0 behaviour
        i_cfg_mode = 2'd1; i_cfg_burst = 8'd200; i_cfg_hold = 1'b0;
        i_cfg_addr = 29'h55; i_cfg_gap = 10'd0;
        apply_reset();
        wait_flag(1, 20, "t4_we_seen");
        check("t4_burstcnt_clamp", {56'd0, o_ddr_burstcnt}, 128);
        check("t4_addr_first",     {35'd0, o_ddr_addr}, 64'h55);
        check("t4_din_b0",         o_ddr_din, 64'h0);
        @(negedge clk); #1;
        check("t4_burstcnt_after", {56'd0, o_ddr_burstcnt}, 1);
        check("t4_addr_after",     {35'd0, o_ddr_addr}, 0);
        check("t4_din_b1",         o_ddr_din, 64'h1);
        wait_bn(1, 400, "t4_bn1");
        wait_flag(1, 20, "t4_we2_seen");
        check("t4_din_n1_b0",      o_ddr_din, 64'h100);
        check("t4_burstcnt_n1",    {56'd0, o_ddr_burstcnt}, 128);
        i_cfg_burst = 8'd0; i_cfg_hold = 1'b1; i_cfg_addr = 29'h77;
        apply_reset();
        wait_flag(1, 20, "t4_we_zero_len");
        check("t4_burstcnt_zero", {56'd0, o_ddr_burstcnt}, 1);
        check("t4_addr_zero",     {35'd0, o_ddr_addr}, 64'h77);
        @(negedge clk); #1;
        check("t4_we_drop",       {63'd0, o_ddr_we}, 0);
        check("t4_addr_hold",     {35'd0, o_ddr_addr}, 64'h77);
        check("t4_bn_single",     {32'd0, o_burst_num}, 1);

        // Test 5: safe_stop mid-read of burst 2
        i_cfg_mode = 2'd0; i_cfg_burst = 8'd16; i_cfg_gap = 10'd2; i_cfg_addr = 29'h10;
        apply_reset();
        wait_bn(2, 500, "t5_bn2");
        wait_flag(3, 20, "t5_reading");
        i_safe_stop = 1'b1;
        @(negedge clk); #1;
        i_safe_stop = 1'b0;
        wait_flag(2, 100, "t5_stopped");
        check("t5_bn",      {32'd0, o_burst_num}, 3);
        check("t5_running", {63'd0, o_running}, 0);
        rds = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (o_ddr_rd) rds++;
        end
        check("t5_no_rd",   rds, 0);
        check("t5_rd_cmds", rd_cmds, 3);

        // Test 6a: abort at write beat 10 of 64 while busy
        i_cfg_mode = 2'd1; i_cfg_burst = 8'd64; i_cfg_gap = 10'd0;
        busy_mode = 0;
        apply_reset();
        begin
            int n;
            n = 0;
            while (wr_beats < 10 && n < 200) begin @(negedge clk); #1; n++; end
        end
        check("t6_ten_beats", wr_beats, 10);
        busy_mode = 2;
        @(negedge clk); #1;
        check("t6_din_b10", o_ddr_din, 64'h0A);
        check("t6_we_busy", {63'd0, o_ddr_we}, 1);
        i_abort = 1'b1;
        @(negedge clk); #1;
        i_abort = 1'b0;
        check("t6_we_drop",   {63'd0, o_ddr_we}, 0);
        check("t6_stopped",   {63'd0, o_stopped}, 1);
        check("t6_bn",        {32'd0, o_burst_num}, 0);
        repeat (5) begin @(negedge clk); #1; end
        check("t6_beats_frozen", wr_beats, 10);

        // Test 6b: safe_stop and abort together stop immediately
        busy_mode = 0; i_cfg_mode = 2'd0; i_cfg_burst = 8'd16;
        apply_reset();
        wait_flag(3, 30, "t6b_reading");
        i_safe_stop = 1'b1; i_abort = 1'b1;
        @(negedge clk); #1;
        i_safe_stop = 1'b0; i_abort = 1'b0;
        check("t6b_stopped", {63'd0, o_stopped}, 1);
        check("t6b_bn",      {32'd0, o_burst_num}, 0);
        repeat (20) begin @(negedge clk); #1; end
        check("t6b_rd_cmds", rd_cmds, 1);

        // Test 6c: reset resumes from IDLE with counters cleared
        apply_reset();
        @(negedge clk); #1;
        check("t6c_stopped", {63'd0, o_stopped}, 0);
        check("t6c_bn",      {32'd0, o_burst_num}, 0);
        wait_flag(0, 20, "t6c_rd_again");
        check("t6c_running", {63'd0, o_running}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
